uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 140 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin byte scheduler that feeds a single UART transmitter.
// Latency: grant one cycle after valid, tx_start one cycle after byte acceptance.
// Backpressure: one byte buffered; ready held low from acceptance until tx_busy falls.
module uart_tx_sched #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TIMEOUT   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  input  logic       req0_last,
  input  logic       req1_last,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       grant_id,
  output logic       pkt_active
);

  // idle_cnt only ever counts up to TIMEOUT-1
  localparam int unsigned IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_LIMIT  = IW'(TIMEOUT - 1);
  localparam logic [7:0]    BURST_LIMIT = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_START  = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t        state_q;
  logic [1:0]    ready_q;
  logic          tx_start_q;
  logic [7:0]    tx_data_q;
  logic          grant_id_q;
  logic          pkt_active_q;
  logic          rr_q;
  logic          last_q;
  logic [7:0]    burst_cnt_q;
  logic [IW-1:0] idle_cnt_q;

  logic          winner_d;
  logic          gnt_valid_d;
  logic [7:0]    gnt_data_d;
  logic          gnt_last_d;
  logic [7:0]    burst_d;
  logic          release_d;

  // Arbitration winner, granted requester's offer and end-of-grant decision.
  always_comb begin
    winner_d    = (req0_valid && req1_valid) ? rr_q : req1_valid;
    gnt_valid_d = grant_id_q ? req1_valid : req0_valid;
    gnt_data_d  = grant_id_q ? req1_data  : req0_data;
    gnt_last_d  = grant_id_q ? req1_last  : req0_last;
    burst_d     = burst_cnt_q + 8'd1;
    release_d   = last_q || (burst_d == BURST_LIMIT);
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ready_q      <= 2'b00;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      grant_id_q   <= 1'b0;
      pkt_active_q <= 1'b0;
      rr_q         <= 1'b0;
      last_q       <= 1'b0;
      burst_cnt_q  <= 8'd0;
      idle_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            grant_id_q   <= winner_d;
            burst_cnt_q  <= 8'd0;
            idle_cnt_q   <= '0;
            pkt_active_q <= 1'b1;
            ready_q      <= winner_d ? 2'b10 : 2'b01;
            state_q      <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (gnt_valid_d) begin
            tx_data_q  <= gnt_data_d;
            last_q     <= gnt_last_d;
            idle_cnt_q <= '0;
            tx_start_q <= 1'b1;
            ready_q    <= 2'b00;
            state_q    <= S_START;
          end else if (idle_cnt_q == IDLE_LIMIT) begin
            // requester stalled mid-packet: hand the link to the other side
            pkt_active_q <= 1'b0;
            ready_q      <= 2'b00;
            rr_q         <= ~grant_id_q;
            state_q      <= S_IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + IW'(1);
          end
        end
        S_START: begin
          if (tx_busy) begin
            tx_start_q <= 1'b0;
            state_q    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!tx_busy) begin
            burst_cnt_q <= burst_d;
            if (release_d) begin
              pkt_active_q <= 1'b0;
              rr_q         <= ~grant_id_q;
              state_q      <= S_IDLE;
            end else begin
              idle_cnt_q <= '0;
              ready_q    <= grant_id_q ? 2'b10 : 2'b01;
              state_q    <= S_ACCEPT;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign grant_id   = grant_id_q;
  assign pkt_active = pkt_active_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
// Small burst cap and timeout so the rotation and stall paths are reached quickly.
`timescale 1ns/1ps
module tb_uart_tx_sched;
  localparam int MB = 4;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_last = 1'b0, req1_last = 1'b0;
  logic       req0_ready, req1_ready, tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       grant_id, pkt_active;

  uart_tx_sched #(.MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_last(req0_last), .req1_last(req1_last),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .pkt_active(pkt_active)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nprint = 0;
  int cyc = 0;

  // stimulus queues: {last, data}
  bit [8:0] q0[$];
  bit [8:0] q1[$];
  int cfg_p = 100;   // percent chance a waiting requester presents its next byte
  int cfg_d = 0;     // busy delay after tx_start (<0: random)
  int cfg_l = 10;    // busy length (<=0: random)

  // observation records
  bit [7:0] dlog[$];
  int r0_rise[$];
  int pkt_fall[$];
  int busy_fall[$];
  int st_hi = 0, r1_hi = 0, rdy_in_start = 0, unstable = 0;
  logic prev_start = 1'b0, prev_r0 = 1'b0, prev_pkt = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // UART transmitter model state
  int b_wait = -1, b_left = 0, b_len = 0;
  bit armed = 1'b0;

  // Reference model: who holds the link, whether a byte is in flight, and
  // whether the transmitter has acknowledged it yet.
  bit m_started = 1'b0, m_active = 1'b0, m_gid = 1'b0, m_ptr = 1'b0;
  bit m_start = 1'b0, m_lastb = 1'b0, m_have = 1'b0, m_seen = 1'b0;
  bit [1:0] m_rdy = 2'b00;
  bit [7:0] m_txd = 8'h00;
  int m_sent = 0, m_wait = 0;
  bit xfer0 = 1'b0, xfer1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < dlog.size()) ? 32'(dlog[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic m_release();
    m_active = 1'b0;
    m_rdy    = 2'b00;
    m_ptr    = ~m_gid;
  endtask

  task automatic model_step();
    bit [1:0] v;
    bit w;
    v = {req1_valid, req0_valid};
    xfer0 = 1'b0;
    xfer1 = 1'b0;
    if (rst) begin
      m_started = 1'b1; m_active = 1'b0; m_gid = 1'b0; m_ptr = 1'b0;
      m_start = 1'b0; m_lastb = 1'b0; m_have = 1'b0; m_seen = 1'b0;
      m_rdy = 2'b00; m_txd = 8'h00; m_sent = 0; m_wait = 0;
      return;
    end
    xfer0 = v[0] & m_rdy[0];
    xfer1 = v[1] & m_rdy[1];
    if (!m_active) begin
      if (v != 2'b00) begin
        w = (v == 2'b11) ? m_ptr : v[1];
        m_gid = w; m_active = 1'b1; m_sent = 0; m_wait = 0;
        m_rdy = w ? 2'b10 : 2'b01;
      end
    end else if (!m_have) begin
      if (v[m_gid]) begin
        m_txd   = m_gid ? req1_data : req0_data;
        m_lastb = m_gid ? req1_last : req0_last;
        m_start = 1'b1; m_have = 1'b1; m_seen = 1'b0;
        m_rdy = 2'b00; m_wait = 0;
      end else if (m_wait == TO - 1) begin
        m_release();
      end else begin
        m_wait++;
      end
    end else if (!m_seen) begin
      if (tx_busy) begin
        m_seen = 1'b1;
        m_start = 1'b0;
      end
    end else if (!tx_busy) begin
      m_sent++;
      m_have = 1'b0;
      if (m_lastb || m_sent == MB) m_release();
      else begin
        m_rdy = m_gid ? 2'b10 : 2'b01;
        m_wait = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare, observation, then transmitter and requester stimulus.
  initial forever begin
    logic [12:0] got, exp;
    int d;
    @(negedge clk);
    cyc++;
    got = {req0_ready, req1_ready, tx_start, tx_data, grant_id, pkt_active};
    exp = {m_rdy[0], m_rdy[1], m_start, m_txd, m_gid, m_active};
    if (m_started) begin
      checks++;
      if (got !== exp) begin
        errors++;
        if (nprint < 20)
          $display("FAIL cycle %0d outputs {r0,r1,start,data,gid,pkt}: got %h expected %h", cyc, got, exp);
        nprint++;
      end
    end
    if (tx_start && !prev_start) dlog.push_back(tx_data);
    if (tx_start) st_hi++;
    if (tx_start && (req0_ready || req1_ready)) rdy_in_start++;
    if (tx_start && prev_start && tx_data !== prev_data) unstable++;
    if (req1_ready) r1_hi++;
    if (req0_ready && !prev_r0) r0_rise.push_back(cyc);
    if (!pkt_active && prev_pkt) pkt_fall.push_back(cyc);
    prev_start = tx_start; prev_r0 = req0_ready; prev_pkt = pkt_active; prev_data = tx_data;

    if (tx_busy) begin
      b_left--;
      if (b_left <= 0) begin
        tx_busy = 1'b0;
        busy_fall.push_back(cyc);
      end
    end else if (b_wait >= 0) begin
      if (b_wait == 0) begin
        tx_busy = 1'b1; b_left = b_len; b_wait = -1;
      end else b_wait--;
    end else if (m_start && !armed) begin
      armed = 1'b1;
      b_len = (cfg_l > 0) ? cfg_l : $urandom_range(1, 12);
      d = (cfg_d >= 0) ? cfg_d : $urandom_range(0, 4);
      if (d == 0) begin
        tx_busy = 1'b1; b_left = b_len;
      end else b_wait = d - 1;
    end
    if (!m_start) armed = 1'b0;

    if (xfer0) begin req0_valid = 1'b0; req0_data = 8'($urandom); end
    if (xfer1) begin req1_valid = 1'b0; req1_data = 8'($urandom); end
    if (!req0_valid && q0.size() > 0 && $urandom_range(1, 100) <= cfg_p) begin
      {req0_last, req0_data} = q0.pop_front();
      req0_valid = 1'b1;
    end
    if (!req1_valid && q1.size() > 0 && $urandom_range(1, 100) <= cfg_p) begin
      {req1_last, req1_data} = q1.pop_front();
      req1_valid = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid &&
                 !m_active && !tx_busy && b_wait < 0) && n < budget);
    chk({name, " completes in budget"}, 32'(n < budget), 32'd1);
  endtask

  bit [7:0] exp2 [6]  = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
  bit [7:0] exp3 [12] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61,
                          8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59};

  initial begin
    int lb, sb, r1b, bfb, pfb, rb, rsb, ub, n;
    bit [7:0] e0[$];
    bit [7:0] e1[$];

    // reset values while rst is held
    repeat (3) tick();
    chk("reset outputs", 32'({req0_ready, req1_ready, tx_start, tx_data, grant_id, pkt_active}), 32'd0);
    rst = 1'b0;

    // single byte from req1, transmitter acknowledges immediately
    cfg_d = 0; cfg_l = 10; cfg_p = 100;
    lb = dlog.size(); sb = st_hi; r1b = r1_hi; bfb = busy_fall.size(); pfb = pkt_fall.size();
    q1.push_back({1'b1, 8'h41});
    wait_idle("single", 200);
    chk("single tx_start cycles", 32'(st_hi - sb), 32'd1);
    chk("single req1_ready cycles", 32'(r1_hi - r1b), 32'd1);
    chk("single byte count", 32'(dlog.size() - lb), 32'd1);
    chk("single byte", log_at(lb), 32'h41);
    chk("single pkt_active falls 1 cycle after busy",
        (pkt_fall.size() > pfb && busy_fall.size() > bfb) ? 32'(pkt_fall[pfb] - busy_fall[bfb]) : 32'hFFFF_FFFF,
        32'd1);
    chk("single grant_id retained", 32'(grant_id), 32'd1);
    chk("single pkt_active", 32'(pkt_active), 32'd0);

    // contention from reset: req0 wins, packets stay contiguous
    do_reset();
    cfg_d = 1; cfg_l = 4;
    lb = dlog.size();
    q0.push_back({1'b0, 8'h10}); q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h12});
    q1.push_back({1'b0, 8'h20}); q1.push_back({1'b0, 8'h21}); q1.push_back({1'b1, 8'h22});
    wait_idle("contention", 400);
    for (int i = 0; i < 6; i++)
      chk($sformatf("contention byte %0d", i), log_at(lb + i), 32'(exp2[i]));
    chk("contention grant_id", 32'(grant_id), 32'd1);
    chk("contention pkt_active", 32'(pkt_active), 32'd0);

    // burst cap rotates to req1, then req0 resumes with its fifth byte
    do_reset();
    cfg_d = 0; cfg_l = 2;
    lb = dlog.size();
    for (int i = 0; i < 10; i++) q0.push_back({1'b0, 8'(8'h50 + i)});
    q1.push_back({1'b0, 8'h60}); q1.push_back({1'b1, 8'h61});
    wait_idle("burst", 800);
    chk("burst byte count", 32'(dlog.size() - lb), 32'd12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("burst byte %0d", i), log_at(lb + i), 32'(exp3[i]));

    // stalled requester loses the grant after TO cycles in ACCEPT
    do_reset();
    cfg_d = 2; cfg_l = 3;
    lb = dlog.size(); rb = r0_rise.size(); pfb = pkt_fall.size();
    q0.push_back({1'b0, 8'h70});
    q1.push_back({1'b1, 8'h71});
    wait_idle("timeout", 400);
    chk("timeout release distance",
        (pkt_fall.size() > pfb && r0_rise.size() > rb + 1) ? 32'(pkt_fall[pfb] - r0_rise[rb + 1]) : 32'hFFFF_FFFF,
        32'(TO));
    chk("timeout byte 0", log_at(lb), 32'h70);
    chk("timeout waiting req1 served", log_at(lb + 1), 32'h71);
    chk("timeout grant_id", 32'(grant_id), 32'd1);

    // slow acknowledge holds start and data
    do_reset();
    cfg_d = 5; cfg_l = 3;
    lb = dlog.size(); sb = st_hi; rsb = rdy_in_start; ub = unstable;
    q0.push_back({1'b1, 8'h80});
    wait_idle("slow ack", 200);
    chk("slow ack tx_start cycles", 32'(st_hi - sb), 32'd6);
    chk("slow ack ready during start", 32'(rdy_in_start - rsb), 32'd0);
    chk("slow ack data stable", 32'(unstable - ub), 32'd0);
    chk("slow ack byte", log_at(lb), 32'h80);

    // reset while the frame is draining
    do_reset();
    cfg_d = 0; cfg_l = 10;
    lb = dlog.size();
    q0.push_back({1'b1, 8'h90});
    n = 0;
    do begin tick(); n++; end while (!(dlog.size() > lb && tx_busy && !tx_start) && n < 100);
    chk("drain reached", 32'(n < 100), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("outputs after mid-frame reset", 32'({req0_ready, req1_ready, tx_start, tx_data, grant_id, pkt_active}), 32'd0);
    wait_idle("after reset", 100);
    repeat (5) tick();
    chk("no retransmit after reset", 32'(dlog.size() - lb), 32'd1);
    chk("reset drain byte", log_at(lb), 32'h90);

    // randomized packets from both sides
    for (int r = 0; r < 3; r++) begin
      int s0, s1, k0, k1, bad0, bad1, np, len;
      do_reset();
      cfg_d = -1; cfg_l = 0; cfg_p = $urandom_range(20, 100);
      e0.delete(); e1.delete();
      s0 = 0; s1 = 0;
      np = $urandom_range(3, 10);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++) begin
          q0.push_back({b == len - 1, 1'b0, 7'(s0)});
          e0.push_back({1'b0, 7'(s0)});
          s0++;
        end
      end
      np = $urandom_range(3, 10);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++) begin
          q1.push_back({b == len - 1, 1'b1, 7'(s1)});
          e1.push_back({1'b1, 7'(s1)});
          s1++;
        end
      end
      lb = dlog.size();
      wait_idle($sformatf("random round %0d", r), 20000);
      k0 = 0; k1 = 0; bad0 = 0; bad1 = 0;
      for (int i = lb; i < dlog.size(); i++) begin
        if (dlog[i][7]) begin
          if (k1 >= e1.size() || dlog[i] != e1[k1]) bad1++;
          k1++;
        end else begin
          if (k0 >= e0.size() || dlog[i] != e0[k0]) bad0++;
          k0++;
        end
      end
      chk($sformatf("random %0d req0 order", r), 32'(bad0), 32'd0);
      chk($sformatf("random %0d req0 count", r), 32'(k0), 32'(e0.size()));
      chk($sformatf("random %0d req1 order", r), 32'(bad1), 32'd0);
      chk($sformatf("random %0d req1 count", r), 32'(k1), 32'(e1.size()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
